// File: rtl/hc165_pkg.sv
// Shared types and helpers for the HC165 chain scanner.
package hc165_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    SHIFT_LO,
    SHIFT_HI,
    DONE
  } state_t;

  // Counter width able to hold 0..n-1.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/hc165_tick_gen.sv
// Phase counter for the HC165 scanner: ticks on the last cycle of each HALF_DIV phase.
module hc165_tick_gen
  import hc165_pkg::*;
#(
  parameter int HALF_DIV = 25
) (
  input  logic Clk,
  input  logic Rst,
  input  logic restart,
  output logic tick
);

  localparam int W = cnt_w(HALF_DIV);
  localparam logic [W-1:0] LAST = W'(HALF_DIV - 1);

  logic [W-1:0] cnt;

  // restart lands on the cycle a state is left, so each new state sees cnt=0 first
  always_ff @(posedge Clk) begin
    if (Rst || restart) cnt <= '0;
    else if (tick)      cnt <= '0;
    else                cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/hc165_scan_reader.sv
// Periodic 74HC165 chain scanner: drives PL_n/SRCLK, samples QH, posts a DATA_WIDTH word.
// Optional build macro HC165_DEBOUNCE_EN: accept a scan only if it repeats the previous raw scan.
module hc165_scan_reader
  import hc165_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int HALF_DIV    = 25,
  parameter int SCAN_PERIOD = 1_000_000,
  parameter bit MSB_FIRST   = 1'b1
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  scan_en,
  input  logic                  QH,
  output logic                  PL_n,
  output logic                  SRCLK,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  data_valid,
  output logic                  changed,
  output logic                  busy
);

  localparam int PW = cnt_w(SCAN_PERIOD);
  localparam int BW = cnt_w(DATA_WIDTH);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_PERIOD - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  state_t                  state, state_next;
  logic   [1:0]            qh_sync;
  logic                    qh_s;
  logic                    tick;
  logic   [PW-1:0]         per_cnt;
  logic   [BW-1:0]         bit_cnt;
  logic   [DATA_WIDTH-1:0] shreg, shreg_in;
  logic                    start, sample, accept;

  always_ff @(posedge Clk) begin
    if (Rst) qh_sync <= '0;
    else     qh_sync <= {qh_sync[0], QH};
  end
  assign qh_s = qh_sync[1];

  always_ff @(posedge Clk) begin
    if (Rst || !scan_en)      per_cnt <= '0;
    else if (per_cnt == P_LAST) per_cnt <= '0;
    else                      per_cnt <= per_cnt + 1'b1;
  end

  assign start  = scan_en && (per_cnt == '0) && (state == IDLE);
  assign sample = tick && ((state == SETTLE) || (state == SHIFT_LO));
  assign busy   = (state != IDLE);

  hc165_tick_gen #(.HALF_DIV(HALF_DIV)) u_tick (
    .Clk     (Clk),
    .Rst     (Rst),
    .restart (state_next != state),
    .tick    (tick)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start) state_next = LOAD;
      LOAD:     if (tick)  state_next = SETTLE;
      SETTLE:   if (tick)  state_next = SHIFT_HI;
      SHIFT_HI: if (tick)  state_next = SHIFT_LO;
      // bit_cnt still holds the index of the bit being sampled this cycle
      SHIFT_LO: if (tick)  state_next = (bit_cnt == B_LAST) ? DONE : SHIFT_HI;
      DONE:                state_next = IDLE;
      default:             state_next = IDLE;
    endcase
  end

  always_comb begin
    shreg_in = '0;
    if (MSB_FIRST) shreg_in = {shreg[DATA_WIDTH-2:0], qh_s};
    else           shreg_in = {qh_s, shreg[DATA_WIDTH-1:1]};
  end

`ifdef HC165_DEBOUNCE_EN
  logic [DATA_WIDTH-1:0] raw_prev;

  always_ff @(posedge Clk) begin
    if (Rst)                raw_prev <= '0;
    else if (state == DONE) raw_prev <= shreg;
  end
  assign accept = (shreg == raw_prev);
`else
  assign accept = 1'b1;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state      <= IDLE;
      PL_n       <= 1'b1;
      SRCLK      <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      changed    <= 1'b0;
    end else begin
      state      <= state_next;
      // driven from the next state so the pins line up exactly with the state they belong to
      PL_n       <= (state_next != LOAD);
      SRCLK      <= (state_next == SHIFT_HI);
      data_valid <= 1'b0;
      changed    <= 1'b0;
      if (state == IDLE) bit_cnt <= '0;
      else if (sample)   bit_cnt <= bit_cnt + 1'b1;
      if (sample) shreg <= shreg_in;
      if (state == DONE && accept) begin
        data       <= shreg;
        data_valid <= 1'b1;
        changed    <= (shreg != data);
      end
    end
  end

endmodule

// File: tb/tb_hc165_scan_reader.sv
// Bench for hc165_scan_reader: two DUTs (MSB-first, LSB-first) each scanning a modelled HC165 chain.
module tb_hc165_scan_reader;

  localparam int DW  = 16;
  localparam int HD  = 25;
  localparam int SP  = 1000;
  localparam int LAT = 2 * HD * DW + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scan_en = 1'b0;
  logic [DW-1:0] pins = '0;
  logic          rst_q, en_q;

  logic [1:0]    qh_a, pl_n_a, sclk_a, valid_a, chg_a, busy_a;
  logic [DW-1:0] data_a [2];
  int            rises_a [2];
  int            pllo_a  [2];

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard state, touched only by the main initial block's threads
  int            cd [2];
  int            since [2];
  int            starts [2];
  bit            have_prev [2];
  bit            steady [2];
  logic          pl_prev [2];
  logic [DW-1:0] m_data [2];
  logic [DW-1:0] m_pins [2];
  logic [DW-1:0] m_raw [2];

`ifdef HC165_DEBOUNCE_EN
  int            t6_v [3] = '{0, 0, 1};
  logic [DW-1:0] t6_d [3] = '{16'h00F0, 16'h00F0, 16'h1235};
  logic          t6_c [3] = '{1'b0, 1'b0, 1'b1};
`else
  int            t6_v [3] = '{1, 1, 1};
  logic [DW-1:0] t6_d [3] = '{16'h1234, 16'h1235, 16'h1235};
  logic          t6_c [3] = '{1'b1, 1'b1, 1'b0};
`endif
  logic [DW-1:0] t6_in [3] = '{16'h1234, 16'h1235, 16'h1235};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rst_q <= rst;
    en_q  <= scan_en;
  end

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [DW-1:0] sr = '0;
    logic          sclk_prev = 1'b0;
    logic          pl_prev_c = 1'b1;
    int            rises = 0;
    int            pl_lo = 0;

    hc165_scan_reader #(
      .DATA_WIDTH (DW),
      .HALF_DIV   (HD),
      .SCAN_PERIOD(SP),
      .MSB_FIRST  (g == 0)
    ) u_dut (
      .Clk       (clk),
      .Rst       (rst),
      .scan_en   (scan_en),
      .QH        (qh_a[g]),
      .PL_n      (pl_n_a[g]),
      .SRCLK     (sclk_a[g]),
      .data      (data_a[g]),
      .data_valid(valid_a[g]),
      .changed   (chg_a[g]),
      .busy      (busy_a[g])
    );

    // HC165 chain: parallel load while PL_n low, shift toward QH on SRCLK rise
    always @(negedge clk) begin
      if (!pl_n_a[g]) begin
        if (pl_prev_c) begin
          rises = 0;
          pl_lo = 0;
        end
        sr = pins;
        pl_lo++;
      end else if (sclk_a[g] && !sclk_prev) begin
        sr = sr << 1;
        rises++;
      end
      sclk_prev = sclk_a[g];
      pl_prev_c = pl_n_a[g];
    end

    assign qh_a[g]    = sr[DW-1];
    assign rises_a[g] = rises;
    assign pllo_a[g]  = pl_lo;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = v[DW-1-i];
    return r;
  endfunction

  // Per-cycle model: a scan starting on a PL_n fall must post the chain word LAT samples later.
  task automatic compare_loop();
    logic          exp_v, exp_c, accept;
    logic [DW-1:0] word;
    for (int i = 0; i < 2; i++) begin
      cd[i] = 0; since[i] = 0; starts[i] = 0; have_prev[i] = 0; steady[i] = 0;
      pl_prev[i] = 1'b1; m_data[i] = '0; m_pins[i] = '0; m_raw[i] = '0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        exp_v = 1'b0;
        exp_c = 1'b0;
        if (rst_q) begin
          cd[i] = 0; m_data[i] = '0; m_raw[i] = '0; have_prev[i] = 0;
          check("rst_pl_n", pl_n_a[i], 1);
          check("rst_srclk", sclk_a[i], 0);
        end else begin
          since[i]++;
          if (!en_q) steady[i] = 0;
          if (cd[i] > 0) begin
            cd[i]--;
            if (cd[i] == 0) begin
              word = (i == 0) ? m_pins[i] : rev(m_pins[i]);
`ifdef HC165_DEBOUNCE_EN
              accept = (word == m_raw[i]);
              m_raw[i] = word;
`else
              accept = 1'b1;
`endif
              if (accept) begin
                exp_c = (word != m_data[i]);
                m_data[i] = word;
                exp_v = 1'b1;
              end
              check("srclk_rises", rises_a[i], DW - 1);
              check("pl_low_cycles", pllo_a[i], HD);
            end
          end
          if (!pl_n_a[i] && pl_prev[i]) begin
            check("start_needs_en", en_q, 1);
            if (have_prev[i] && steady[i]) check("scan_period", since[i], SP);
            have_prev[i] = 1; steady[i] = 1; since[i] = 0;
            cd[i] = LAT; m_pins[i] = pins; starts[i]++;
          end
        end
        pl_prev[i] = pl_n_a[i];
        check("data", data_a[i], m_data[i]);
        check("data_valid", valid_a[i], exp_v);
        check("changed", chg_a[i], exp_c);
        check("busy", busy_a[i], cd[i] > 0);
        check("pl_srclk_overlap", !pl_n_a[i] && sclk_a[i], 0);
      end
    end
  endtask

  task automatic wait_start();
    for (int k = 0; k < 2 * SP; k++) begin
      @(negedge clk);
      if (!pl_n_a[0]) return;
    end
    check("start_timeout", 0, 1);
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int k = 1; k <= 3 * SP; k++) begin
      @(negedge clk);
      if (valid_a[0]) begin
        cyc = k;
        return;
      end
    end
    check("valid_timeout", 0, 1);
  endtask

`ifdef HC165_DEBOUNCE_EN
  task automatic prime();
    wait_start();
    repeat (LAT) @(negedge clk);
  endtask
`endif

  initial begin
    int cyc, n0, nv;
    logic lastc;
    fork
      compare_loop();
    join_none

    repeat (3) @(negedge clk);
    check("reset_data", data_a[0], 16'h0000);
    check("reset_pl_n", pl_n_a[0], 1);
    check("reset_busy", busy_a[0], 0);
    check("reset_valid", valid_a[0], 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: A55A, first scan starts as soon as scan_en rises
    pins = 16'hA55A;
`ifdef HC165_DEBOUNCE_EN
    scan_en = 1'b1;
    prime();
    wait_start();
`else
    scan_en = 1'b1;
    @(negedge clk);
    check("t1_immediate_start", pl_n_a[0], 0);
`endif
    wait_valid(cyc);
    check("t1_latency", cyc, 801);
    check("t1_data_msb", data_a[0], 16'hA55A);
    check("t1_data_lsb", data_a[1], 16'h5AA5);
    check("t1_changed", chg_a[0], 1);
    check("t1_rises", rises_a[0], 15);
    check("t1_pl_low", pllo_a[0], 25);

    // 2: same input again
    wait_start();
    wait_valid(cyc);
    check("t2_latency", cyc, 801);
    check("t2_data", data_a[0], 16'hA55A);
    check("t2_changed", chg_a[0], 0);

    // 3: bit placement
    pins = 16'h0001;
`ifdef HC165_DEBOUNCE_EN
    prime();
`endif
    wait_start();
    wait_valid(cyc);
    check("t3_msb_first", data_a[0], 16'h0001);
    check("t3_lsb_first", data_a[1], 16'h8000);
    check("t3_changed", chg_a[1], 1);

    // 4: reset at bit 7 of an all-ones scan
    pins = 16'hFFFF;
    wait_start();
    for (int k = 0; k < LAT; k++) begin
      @(negedge clk);
      if (rises_a[0] == 7) break;
    end
    check("t4_reached_bit7", rises_a[0], 7);
    rst = 1'b1;
    @(negedge clk);
    check("t4_pl_n", pl_n_a[0], 1);
    check("t4_srclk", sclk_a[0], 0);
    check("t4_data", data_a[0], 16'h0000);
    check("t4_busy", busy_a[0], 0);
    check("t4_valid", valid_a[0], 0);
    rst = 1'b0;
`ifdef HC165_DEBOUNCE_EN
    prime();
`endif
    wait_start();
    wait_valid(cyc);
    check("t4_rescan", data_a[0], 16'hFFFF);
    check("t4_rescan_lsb", data_a[1], 16'hFFFF);

    // 5: scan_en dropped mid-scan
    pins = 16'h00F0;
`ifdef HC165_DEBOUNCE_EN
    prime();
`endif
    wait_start();
    repeat (100) @(negedge clk);
    scan_en = 1'b0;
    wait_valid(cyc);
    check("t5_latency", cyc, 701);
    check("t5_data", data_a[0], 16'h00F0);
    n0 = starts[0];
    repeat (2 * SP) @(negedge clk);
    check("t5_no_restart", starts[0], n0);
    check("t5_idle", busy_a[0], 0);
    scan_en = 1'b1;
    @(negedge clk);
    check("t5_restart", pl_n_a[0], 0);
    wait_valid(cyc);
    check("t5_changed", chg_a[0], 0);

    // 6: 1234, 1235, 1235 on consecutive scans
    for (int s = 0; s < 3; s++) begin
      pins = t6_in[s];
      wait_start();
      nv = 0;
      lastc = 1'b0;
      repeat (LAT + 1) begin
        @(negedge clk);
        if (valid_a[0]) begin
          nv++;
          lastc = chg_a[0];
        end
      end
      check("t6_valid_count", nv, t6_v[s]);
      check("t6_data", data_a[0], t6_d[s]);
      check("t6_changed", lastc, t6_c[s]);
    end

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
